// File: rtl/stump_control_fsm.sv
// Multi-cycle FETCH/EXECUTE/MEMORY sequencer for the Stump 16-bit datapath.
// Decodes the latched IR into datapath controls and guards memory handshakes with a wait-state timeout.
module stump_control_fsm #(
    parameter int WAIT_LIMIT = 15,
    parameter int WAIT_W     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ir,
    input  logic [3:0]  cc_flags,
    input  logic        mem_ready,
    output logic [1:0]  state,
    output logic        fetch,
    output logic        ir_en,
    output logic        mem_req,
    output logic        mem_wen,
    output logic        reg_write,
    output logic [2:0]  dest,
    output logic [2:0]  srcA,
    output logic [2:0]  srcB,
    output logic [1:0]  shift_op,
    output logic        opB_sel,
    output logic        ext_op,
    output logic        wb_mem,
    output logic [2:0]  alu_func,
    output logic        cc_en,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_EXECUTE = 2'b01,
        ST_MEMORY  = 2'b10,
        ST_ERROR   = 2'b11
    } state_t;

    localparam logic [2:0]        OP_LDST  = 3'd6;
    localparam logic [2:0]        OP_BCC   = 3'd7;
    localparam logic [2:0]        REG_PC   = 3'd7;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    state_t            state_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              bus_error_r;

    logic [2:0] op_s;
    logic       type_s;
    logic       s_bit_s;
    logic [2:0] dst_s;
    logic [2:0] src_a_s;
    logic [2:0] src_b_s;
    logic [1:0] shift_s;
    logic [3:0] cond_s;
    logic       cond_true_s;
    logic       access_s;
    logic       timeout_s;

    // Branch condition evaluation against {N,Z,V,C}
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n_v, z_v, v_v, c_v;
        logic res_v;
        n_v = flags[3];
        z_v = flags[2];
        v_v = flags[1];
        c_v = flags[0];
        case (cond)
            4'h0:    res_v = 1'b1;
            4'h1:    res_v = 1'b0;
            4'h2:    res_v = ~c_v & ~z_v;
            4'h3:    res_v = c_v | z_v;
            4'h4:    res_v = ~c_v;
            4'h5:    res_v = c_v;
            4'h6:    res_v = ~z_v;
            4'h7:    res_v = z_v;
            4'h8:    res_v = ~v_v;
            4'h9:    res_v = v_v;
            4'hA:    res_v = ~n_v;
            4'hB:    res_v = n_v;
            4'hC:    res_v = (n_v == v_v);
            4'hD:    res_v = (n_v != v_v);
            4'hE:    res_v = ~z_v & (n_v == v_v);
            4'hF:    res_v = z_v | (n_v != v_v);
            default: res_v = 1'b0;
        endcase
        return res_v;
    endfunction

    assign op_s        = ir[15:13];
    assign type_s      = ir[12];
    assign s_bit_s     = ir[11];
    assign dst_s       = ir[10:8];
    assign src_a_s     = ir[7:5];
    assign src_b_s     = ir[4:2];
    assign shift_s     = ir[1:0];
    assign cond_s      = ir[11:8];
    assign cond_true_s = cond_eval(cond_s, cc_flags);

    // A bus access is pending in FETCH and MEMORY; the timeout fires on a not-ready cycle at the limit
    assign access_s  = (state_r == ST_FETCH) || (state_r == ST_MEMORY);
    assign timeout_s = access_s && !mem_ready && (wait_cnt_r == WAIT_MAX);

    assign state     = state_r;
    assign bus_error = bus_error_r;

    // Sequencer state, wait-state counter and sticky bus error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_FETCH;
            wait_cnt_r  <= {WAIT_W{1'b0}};
            bus_error_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (mem_ready) begin
                        state_r    <= ST_EXECUTE;
                        wait_cnt_r <= {WAIT_W{1'b0}};
                    end else if (timeout_s) begin
                        state_r     <= ST_ERROR;
                        wait_cnt_r  <= {WAIT_W{1'b0}};
                        bus_error_r <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                    end
                end
                ST_EXECUTE: begin
                    state_r    <= (op_s == OP_LDST) ? ST_MEMORY : ST_FETCH;
                    wait_cnt_r <= {WAIT_W{1'b0}};
                end
                ST_MEMORY: begin
                    if (mem_ready) begin
                        state_r    <= ST_FETCH;
                        wait_cnt_r <= {WAIT_W{1'b0}};
                    end else if (timeout_s) begin
                        state_r     <= ST_ERROR;
                        wait_cnt_r  <= {WAIT_W{1'b0}};
                        bus_error_r <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                    end
                end
                ST_ERROR: begin
                    state_r     <= ST_ERROR;
                    wait_cnt_r  <= {WAIT_W{1'b0}};
                    bus_error_r <= 1'b1;
                end
                default: begin
                    state_r    <= ST_ERROR;
                    wait_cnt_r <= {WAIT_W{1'b0}};
                end
            endcase
        end
    end

    // Datapath control decode from current state and IR
    always_comb begin
        fetch     = 1'b0;
        ir_en     = 1'b0;
        mem_req   = 1'b0;
        mem_wen   = 1'b0;
        reg_write = 1'b0;
        dest      = 3'b000;
        srcA      = 3'b000;
        srcB      = 3'b000;
        shift_op  = 2'b00;
        opB_sel   = 1'b0;
        ext_op    = 1'b0;
        wb_mem    = 1'b0;
        alu_func  = 3'b000;
        cc_en     = 1'b0;
        case (state_r)
            ST_FETCH: begin
                fetch   = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_en     = 1'b1;
                    reg_write = 1'b1;
                    dest      = REG_PC;
                end else begin
                    ir_en     = 1'b0;
                    reg_write = 1'b0;
                end
            end
            ST_EXECUTE: begin
                if (op_s == OP_BCC) begin
                    srcA      = REG_PC;
                    opB_sel   = 1'b1;
                    ext_op    = 1'b1;
                    dest      = REG_PC;
                    reg_write = cond_true_s;
                end else begin
                    srcA    = src_a_s;
                    opB_sel = type_s;
                    // Register operand and shift only apply to the register form
                    if (!type_s) begin
                        srcB     = src_b_s;
                        shift_op = shift_s;
                    end else begin
                        srcB     = 3'b000;
                        shift_op = 2'b00;
                    end
                    if (op_s == OP_LDST) begin
                        alu_func  = 3'b000;
                        reg_write = 1'b0;
                        cc_en     = 1'b0;
                    end else begin
                        alu_func  = op_s;
                        reg_write = 1'b1;
                        dest      = dst_s;
                        cc_en     = s_bit_s;
                    end
                end
            end
            ST_MEMORY: begin
                mem_req = 1'b1;
                mem_wen = s_bit_s;
                if (s_bit_s) begin
                    srcA = dst_s;
                end else if (mem_ready) begin
                    reg_write = 1'b1;
                    dest      = dst_s;
                    wb_mem    = 1'b1;
                end else begin
                    reg_write = 1'b0;
                end
            end
            ST_ERROR: begin
                fetch = 1'b0;
            end
            default: begin
                fetch = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_stump_control_fsm.sv
// Self-checking bench for stump_control_fsm: directed scenarios then randomized traffic
// checked against a phase-level behavioural model of the sequencer.
module tb_stump_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ir;
    logic [3:0]  cc_flags;
    logic        mem_ready;
    logic [1:0]  state;
    logic        fetch, ir_en, mem_req, mem_wen, reg_write;
    logic [2:0]  dest, srcA, srcB;
    logic [1:0]  shift_op;
    logic        opB_sel, ext_op, wb_mem;
    logic [2:0]  alu_func;
    logic        cc_en, bus_error;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: phase 0 fetch, 1 execute, 2 memory, 3 error
    int m_phase;
    int m_wait;
    bit m_berr;

    stump_control_fsm #(.WAIT_LIMIT(15), .WAIT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .cc_flags(cc_flags), .mem_ready(mem_ready),
        .state(state), .fetch(fetch), .ir_en(ir_en), .mem_req(mem_req), .mem_wen(mem_wen),
        .reg_write(reg_write), .dest(dest), .srcA(srcA), .srcB(srcB), .shift_op(shift_op),
        .opB_sel(opB_sel), .ext_op(ext_op), .wb_mem(wb_mem), .alu_func(alu_func),
        .cc_en(cc_en), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    // Conditions come in complementary pairs; odd codes invert the even base
    function automatic bit cond_true(input logic [3:0] cond, input logic [3:0] f);
        bit n = f[3], z = f[2], v = f[1], c = f[0];
        bit base;
        case (cond[3:1])
            3'd0: base = 1'b1;
            3'd1: base = !c && !z;
            3'd2: base = !c;
            3'd3: base = !z;
            3'd4: base = !v;
            3'd5: base = !n;
            3'd6: base = (n == v);
            3'd7: base = !z && (n == v);
            default: base = 1'b0;
        endcase
        return cond[0] ? !base : base;
    endfunction

    task automatic chk(input string tag, input string field, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        int op = int'(ir[15:13]);
        bit ty = ir[12], s = ir[11];
        logic [2:0] dst = ir[10:8], sa = ir[7:5], sb = ir[4:2];
        logic [1:0] sh = ir[1:0];
        logic [1:0] e_state = 2'(m_phase);
        logic e_fetch = 0, e_iren = 0, e_req = 0, e_wen = 0, e_rw = 0, e_opb = 0, e_ext = 0, e_wb = 0, e_cc = 0;
        logic [2:0] e_dest = 0, e_sa = 0, e_sb = 0, e_alu = 0;
        logic [1:0] e_sh = 0;
        if (m_phase == 0) begin
            e_fetch = 1; e_req = 1;
            if (mem_ready) begin e_iren = 1; e_rw = 1; e_dest = 3'd7; end
        end else if (m_phase == 1) begin
            if (op == 7) begin
                e_sa = 3'd7; e_opb = 1; e_ext = 1; e_dest = 3'd7; e_rw = cond_true(ir[11:8], cc_flags);
            end else begin
                e_sa = sa; e_opb = ty;
                if (!ty) begin e_sb = sb; e_sh = sh; end
                if (op < 6) begin e_alu = 3'(op); e_rw = 1; e_dest = dst; e_cc = s; end
            end
        end else if (m_phase == 2) begin
            e_req = 1; e_wen = s;
            if (s) e_sa = dst;
            else if (mem_ready) begin e_rw = 1; e_dest = dst; e_wb = 1; end
        end
        chk(tag, "state", 16'(state), 16'(e_state));
        chk(tag, "fetch", 16'(fetch), 16'(e_fetch));
        chk(tag, "ir_en", 16'(ir_en), 16'(e_iren));
        chk(tag, "mem_req", 16'(mem_req), 16'(e_req));
        chk(tag, "mem_wen", 16'(mem_wen), 16'(e_wen));
        chk(tag, "reg_write", 16'(reg_write), 16'(e_rw));
        chk(tag, "dest", 16'(dest), 16'(e_dest));
        chk(tag, "srcA", 16'(srcA), 16'(e_sa));
        chk(tag, "srcB", 16'(srcB), 16'(e_sb));
        chk(tag, "shift_op", 16'(shift_op), 16'(e_sh));
        chk(tag, "opB_sel", 16'(opB_sel), 16'(e_opb));
        chk(tag, "ext_op", 16'(ext_op), 16'(e_ext));
        chk(tag, "wb_mem", 16'(wb_mem), 16'(e_wb));
        chk(tag, "alu_func", 16'(alu_func), 16'(e_alu));
        chk(tag, "cc_en", 16'(cc_en), 16'(e_cc));
        chk(tag, "bus_error", 16'(bus_error), 16'(m_berr));
    endtask

    task automatic model_reset();
        m_phase = 0; m_wait = 0; m_berr = 0;
    endtask

    // Advance the model by one clock using the inputs present before the edge
    task automatic model_clock(input logic [15:0] i, input logic r);
        if (m_phase == 0 || m_phase == 2) begin
            if (r) begin
                m_phase = (m_phase == 0) ? 1 : 0; m_wait = 0;
            end else if (m_wait == 15) begin
                m_phase = 3; m_wait = 0; m_berr = 1;
            end else begin
                m_wait++;
            end
        end else if (m_phase == 1) begin
            m_phase = (i[15:13] == 3'd6) ? 2 : 0; m_wait = 0;
        end
    endtask

    // One clock: drive inputs at the falling edge, check, clock, return to the falling edge
    task automatic step(input logic [15:0] i, input logic r, input logic [3:0] f, input string tag);
        ir = i; mem_ready = r; cc_flags = f;
        #1;
        check_outputs(tag);
        @(posedge clk);
        model_clock(i, r);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between clock edges, released at a falling edge
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] rir;
        logic        rrdy;
        rst_n = 1'b0; ir = 16'h0000; mem_ready = 1'b0; cc_flags = 4'h0;
        model_reset();
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ADD R1,R2,#3 with S set
        step(16'h1943, 1'b1, 4'h0, "add_fetch");
        step(16'h1943, 1'b0, 4'h0, "add_exec");
        step(16'h1943, 1'b0, 4'h0, "add_back");
        async_reset("rst_a");

        // ST R3,[R4] with two wait states
        step(16'hDB80, 1'b1, 4'h0, "st_fetch");
        step(16'hDB80, 1'b0, 4'h0, "st_exec");
        step(16'hDB80, 1'b0, 4'h0, "st_mem0");
        step(16'hDB80, 1'b0, 4'h0, "st_mem1");
        step(16'hDB80, 1'b1, 4'h0, "st_mem2");
        step(16'hDB80, 1'b1, 4'h0, "st_back");

        // BEQ +5 taken then not taken
        step(16'hE705, 1'b0, 4'b0100, "beq_t_exec");
        step(16'hE705, 1'b1, 4'b0000, "beq_fetch");
        step(16'hE705, 1'b0, 4'b0000, "beq_n_exec");
        async_reset("rst_b");

        // Sixteen not-ready fetch cycles end in the error state
        for (int k = 0; k < 16; k++) step(16'h0000, 1'b0, 4'h0, "to_wait");
        for (int k = 0; k < 3; k++) step(16'h0000, 1'b1, 4'h0, "to_err");
        async_reset("rst_c");

        // Ready on the sixteenth cycle is still accepted
        for (int k = 0; k < 15; k++) step(16'h0000, 1'b0, 4'h0, "lim_wait");
        step(16'h0000, 1'b1, 4'h0, "lim_ready");
        step(16'h0000, 1'b0, 4'h0, "lim_exec");

        // Reset in the middle of a load's memory phase
        step(16'hC390, 1'b1, 4'h0, "ld_fetch");
        step(16'hC390, 1'b1, 4'h0, "ld_exec");
        step(16'hC390, 1'b0, 4'h0, "ld_mem");
        async_reset("ld_abort");
        step(16'hC390, 1'b0, 4'h0, "ld_after");

        // Randomized traffic; a low-ready window drives timeouts
        rir = 16'h0000;
        for (int n = 0; n < 2500; n++) begin
            if (m_phase == 3 || $urandom_range(0, 299) == 0) begin
                async_reset("rnd_rst");
            end else begin
                if (m_phase == 0) rir = 16'($urandom);
                if (n >= 1200 && n < 1600) rrdy = ($urandom_range(0, 15) == 0);
                else rrdy = ($urandom_range(0, 3) != 0);
                step(rir, rrdy, 4'($urandom), "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
